sim_por_status_seq: RTL and testbench



---
 rtl/sim_por_status_seq.sv | 191 +++++++++++++++++++
 tb/tb_sim_por_status_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_por_status_seq.sv
// sim_por_status_seq: power-on-reset sequencer and SW test-status monitor for
// the FPGA-sim top-level bench. After start_i it holds POR_N high for
// PreRstCycles, drives it low for RstCycles, then watches status writes to
// StatusAddr and ends in PASS, FAIL or TMO. A bench wrapper turns done_o
// into $finish.
//
// Optional build macro SIM_POR_SEQ_RETRY_EN: FAIL/TMO outcomes re-run the
// POR sequence up to two more times and retries_o reports retries consumed.
//
// Handshake: wr_valid_i is a plain strobe with no back-pressure; every cycle
// it is high is exactly one write, sampled on the rising edge of clk_i.
module sim_por_status_seq #(
   parameter int unsigned PreRstCycles  = 2000,
   parameter int unsigned RstCycles     = 1000,
   parameter int unsigned TimeoutCycles = 10000000,
   parameter logic [31:0] StatusAddr    = 32'h0041_1000,
   parameter int unsigned CntW          = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        wr_valid_i,
   input  logic [31:0] addr_i,
   input  logic [15:0] data_i,
   output logic        por_no,
   output logic [2:0]  state_o,
   output logic        done_o,
   output logic        passed_o,
   output logic        timeout_o,
   output logic [15:0] last_status_o
`ifdef SIM_POR_SEQ_RETRY_EN
   ,
   output logic [1:0]  retries_o
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRE    = 3'd1,
      ST_ASSERT = 3'd2,
      ST_RUN    = 3'd3,
      ST_PASS   = 3'd4,
      ST_FAIL   = 3'd5,
      ST_TMO    = 3'd6
   } state_e;

   localparam logic [15:0] CodePass = 16'h900D;
   localparam logic [15:0] CodeFail = 16'hBAAD;

   // Last counter value of each timed phase; a zero-length phase still lasts
   // one cycle, which also gives the minimum one-cycle POR pulse.
   localparam logic [CntW-1:0] CntOne  = 1;
   localparam logic [CntW-1:0] PreLast = (PreRstCycles == 0) ? '0 : CntW'(PreRstCycles - 1);
   localparam logic [CntW-1:0] RstLast = (RstCycles == 0) ? '0 : CntW'(RstCycles - 1);
   localparam logic [CntW-1:0] TmoLast = (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            por_n_q, por_n_d;
   logic            done_q, done_d;
   logic            passed_q, passed_d;
   logic            timeout_q, timeout_d;
   logic [15:0]     last_status_q, last_status_d;
`ifdef SIM_POR_SEQ_RETRY_EN
   logic [1:0]      retry_q, retry_d;
`endif

   logic   hit;
   logic   restart;
   logic   bad_end;
   state_e bad_state;

   // A start pulse never cuts a POR pulse short, so it is ignored in ASSERT.
   assign restart = start_i && (state_q != ST_ASSERT);
   assign hit     = wr_valid_i && (addr_i == StatusAddr);

   // State register plus all registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         por_n_q       <= 1'b1;
         done_q        <= 1'b0;
         passed_q      <= 1'b0;
         timeout_q     <= 1'b0;
         last_status_q <= 16'h0;
`ifdef SIM_POR_SEQ_RETRY_EN
         retry_q       <= 2'd0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         por_n_q       <= por_n_d;
         done_q        <= done_d;
         passed_q      <= passed_d;
         timeout_q     <= timeout_d;
         last_status_q <= last_status_d;
`ifdef SIM_POR_SEQ_RETRY_EN
         retry_q       <= retry_d;
`endif
      end
   end

   // Next-state and phase counter; a terminal hit beats a same-cycle timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bad_end   = 1'b0;
      bad_state = ST_FAIL;
`ifdef SIM_POR_SEQ_RETRY_EN
      retry_d   = retry_q;
`endif
      if (restart) begin
         state_d = ST_PRE;
         cnt_d   = '0;
`ifdef SIM_POR_SEQ_RETRY_EN
         retry_d = 2'd0;
`endif
      end else begin
         case (state_q)
            ST_PRE: begin
               if (cnt_q == PreLast) begin
                  state_d = ST_ASSERT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            ST_ASSERT: begin
               if (cnt_q == RstLast) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            ST_RUN: begin
               cnt_d = cnt_q + CntOne;
               if (hit && (data_i == CodePass)) begin
                  state_d = ST_PASS;
               end else if (hit && (data_i == CodeFail)) begin
                  bad_end   = 1'b1;
                  bad_state = ST_FAIL;
               end else if (cnt_q == TmoLast) begin
                  bad_end   = 1'b1;
                  bad_state = ST_TMO;
               end
            end
            default: ;
         endcase
         if (bad_end) begin
`ifdef SIM_POR_SEQ_RETRY_EN
            if (retry_q != 2'd2) begin
               state_d = ST_PRE;
               cnt_d   = '0;
               retry_d = retry_q + 2'd1;
            end else begin
               state_d = bad_state;
            end
`else
            state_d = bad_state;
`endif
         end
      end
   end

   // Output values for the next cycle, derived from the next state.
   always_comb begin
      por_n_d       = (state_d != ST_ASSERT);
      done_d        = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TMO);
      passed_d      = (state_d == ST_PASS);
      timeout_d     = (state_d == ST_TMO);
      last_status_d = last_status_q;
      if (restart) begin
         last_status_d = 16'h0;
      end else if ((state_q == ST_RUN) && hit) begin
         last_status_d = data_i;
      end
   end

   assign por_no        = por_n_q;
   assign state_o       = state_q;
   assign done_o        = done_q;
   assign passed_o      = passed_q;
   assign timeout_o     = timeout_q;
   assign last_status_o = last_status_q;
`ifdef SIM_POR_SEQ_RETRY_EN
   assign retries_o     = retry_q;
`endif

endmodule

// File: tb/tb_sim_por_status_seq.sv
// Directed bench for sim_por_status_seq (default build). Main instance uses
// the default POR timing with a short 100-cycle timeout; a second instance
// uses zero-length phases and a 3-cycle timeout.
module tb_sim_por_status_seq;

   localparam logic [31:0] SA = 32'h0041_1000;

   // Clock and reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic        z_start;
   logic        wr_valid;
   logic [31:0] addr;
   logic [15:0] data;

   logic        por_n, done, passed, tmo;
   logic [2:0]  state;
   logic [15:0] last;
   logic        z_por_n, z_done, z_passed, z_tmo;
   logic [2:0]  z_state;
   logic [15:0] z_last;

   sim_por_status_seq #(
      .PreRstCycles(2000), .RstCycles(1000), .TimeoutCycles(100),
      .StatusAddr(SA), .CntW(32)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .wr_valid_i(wr_valid),
      .addr_i(addr), .data_i(data), .por_no(por_n), .state_o(state),
      .done_o(done), .passed_o(passed), .timeout_o(tmo), .last_status_o(last)
   );

   sim_por_status_seq #(
      .PreRstCycles(0), .RstCycles(0), .TimeoutCycles(3),
      .StatusAddr(SA), .CntW(8)
   ) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .start_i(z_start), .wr_valid_i(wr_valid),
      .addr_i(addr), .data_i(data), .por_no(z_por_n), .state_o(z_state),
      .done_o(z_done), .passed_o(z_passed), .timeout_o(z_tmo), .last_status_o(z_last)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [15:0] d);
      wr_valid = 1'b1;
      addr     = a;
      data     = d;
      tick();
      wr_valid = 1'b0;
      addr     = '0;
      data     = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Bounded wait for a main-instance state; an expired bound fails the check.
   task automatic wait_state(input logic [2:0] s, input int bound, output int n);
      n = 0;
      while (state !== s && n < bound) begin
         tick();
         n++;
      end
      chk("wait_state", {29'd0, state}, {29'd0, s});
   endtask

   int n;
   int w;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      z_start  = 1'b0;
      wr_valid = 1'b0;
      addr     = '0;
      data     = '0;
      repeat (3) tick();

      // Reset values
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_por", {31'd0, por_n}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_passed", {31'd0, passed}, 32'd0);
      chk("rst_timeout", {31'd0, tmo}, 32'd0);
      chk("rst_last", {16'd0, last}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Writes in IDLE are ignored
      wr(SA, 16'h4354);
      chk("idle_wr_ignored", {16'd0, last}, 32'd0);

      // Zero-length phases: one PRE cycle, one-cycle POR pulse, 3-cycle RUN
      z_start = 1'b1;
      tick();
      z_start = 1'b0;
      chk("z_pre", {29'd0, z_state}, 32'd1);
      tick();
      chk("z_assert", {29'd0, z_state}, 32'd2);
      chk("z_por_low", {31'd0, z_por_n}, 32'd0);
      tick();
      chk("z_run", {29'd0, z_state}, 32'd3);
      chk("z_por_high", {31'd0, z_por_n}, 32'd1);
      tick();
      tick();
      chk("z_run_last", {29'd0, z_state}, 32'd3);
      tick();
      chk("z_tmo", {29'd0, z_state}, 32'd6);
      chk("z_timeout_o", {31'd0, z_tmo}, 32'd1);

      // Full POR sequence: 2000 high, 1000 low, then RUN
      pulse_start();
      chk("pre_state", {29'd0, state}, 32'd1);
      wait_state(3'd2, 3000, n);
      chk("pre_len", n, 2000);
      w = 0;
      while (por_n === 1'b0 && w < 5000) begin
         tick();
         w++;
      end
      chk("por_width", w, 1000);
      chk("run_entry", {29'd0, state}, 32'd3);

      // 4354 then 900D -> PASS
      wr(SA, 16'h4354);
      chk("in_test_last", {16'd0, last}, 32'h4354);
      chk("in_test_state", {29'd0, state}, 32'd3);
      chk("in_test_done", {31'd0, done}, 32'd0);
      wr(SA, 16'h900D);
      chk("pass_state", {29'd0, state}, 32'd4);
      chk("pass_last", {16'd0, last}, 32'h900D);
      chk("pass_done", {31'd0, done}, 32'd1);
      chk("pass_passed", {31'd0, passed}, 32'd1);
      repeat (3) tick();
      chk("pass_hold", {29'd0, state}, 32'd4);

      // Restart from PASS clears outputs; wrong address ignored; BAAD -> FAIL
      pulse_start();
      chk("restart_state", {29'd0, state}, 32'd1);
      chk("restart_done", {31'd0, done}, 32'd0);
      chk("restart_last", {16'd0, last}, 32'd0);
      wait_state(3'd3, 3100, n);
      wr(SA + 32'd4, 16'hBAAD);
      chk("wrong_addr_last", {16'd0, last}, 32'd0);
      chk("wrong_addr_state", {29'd0, state}, 32'd3);
      wr(SA, 16'hBAAD);
      chk("fail_state", {29'd0, state}, 32'd5);
      chk("fail_last", {16'd0, last}, 32'hBAAD);
      chk("fail_done", {31'd0, done}, 32'd1);
      chk("fail_passed", {31'd0, passed}, 32'd0);

      // No writes -> TMO exactly 100 cycles after RUN entry
      pulse_start();
      wait_state(3'd3, 3100, n);
      w = 0;
      while (state === 3'd3 && w < 200) begin
         tick();
         w++;
      end
      chk("tmo_len", w, 100);
      chk("tmo_state", {29'd0, state}, 32'd6);
      chk("tmo_timeout", {31'd0, tmo}, 32'd1);
      chk("tmo_done", {31'd0, done}, 32'd1);
      chk("tmo_passed", {31'd0, passed}, 32'd0);

      // 900D on the 100th RUN cycle beats the timeout
      pulse_start();
      wait_state(3'd3, 3100, n);
      repeat (99) tick();
      chk("last_run_cycle", {29'd0, state}, 32'd3);
      wr(SA, 16'h900D);
      chk("race_state", {29'd0, state}, 32'd4);
      chk("race_timeout", {31'd0, tmo}, 32'd0);
      chk("race_passed", {31'd0, passed}, 32'd1);

      // start during ASSERT does not shorten the pulse
      pulse_start();
      wait_state(3'd2, 3000, n);
      repeat (10) tick();
      pulse_start();
      chk("assert_start_ignored", {29'd0, state}, 32'd2);
      w = 11;
      while (por_n === 1'b0 && w < 5000) begin
         tick();
         w++;
      end
      chk("assert_start_width", w, 1000);

      // Reset mid-ASSERT: POR_N high and IDLE right after the edge
      pulse_start();
      wait_state(3'd2, 3000, n);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_por", {31'd0, por_n}, 32'd1);
      chk("mid_rst_state", {29'd0, state}, 32'd0);
      chk("mid_rst_last", {16'd0, last}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("post_rst_idle", {29'd0, state}, 32'd0);

      // Final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
